// File: rtl/fwd_hazard_ctrl_if.sv
// Forwarding/hazard select bundle between ID/EX datapath and controller.
// master = controller (drives selects), slave = datapath.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              stall;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic              id_bypass_a;
  logic              id_bypass_b;

  modport master (
    input  id_valid, id_rs, id_rt, id_dest,
    input  id_reg_write, id_mem_read, flush,
    output stall, fwd_a, fwd_b,
    output id_bypass_a, id_bypass_b
  );

  modport slave (
    output id_valid, id_rs, id_rt, id_dest,
    output id_reg_write, id_mem_read, flush,
    input  stall, fwd_a, fwd_b,
    input  id_bypass_a, id_bypass_b
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall control for the 5-stage pipe.
// Optional WB->ID bypass enabled by defining FWD_WB_BYPASS_EN.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input logic             clk,
  input logic             rst,
  fwd_hazard_ctrl_if.master hz
);

  typedef struct packed {
    logic              v;
    logic              rw;
    logic              mr;
    logic [REG_AW-1:0] dest;
  } ent_t;

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(2);

  ent_t             ex_e;
  ent_t             mem_e;
  logic [SEL_W-1:0] fwd_a;
  logic [SEL_W-1:0] fwd_b;
  logic [SEL_W-1:0] nxt_a;
  logic [SEL_W-1:0] nxt_b;
  logic             stall;
  logic             issue;

  // $0 is never a forwarding source.
  function automatic logic live(ent_t e);
    return e.v & e.rw & (e.dest != '0);
  endfunction

  // ex_e is younger than mem_e, so it wins.
  function automatic logic [SEL_W-1:0] pick(
    ent_t              ex,
    ent_t              mem,
    logic [REG_AW-1:0] src
  );
    if (live(ex) && ex.dest == src)
      return SEL_EX;
    else if (live(mem) && mem.dest == src)
      return SEL_MEM;
    else
      return SEL_RF;
  endfunction

  // Load in EX feeding the ID instruction; flush overrides.
  always_comb begin
    stall = hz.id_valid & ~hz.flush & ex_e.mr & live(ex_e) &
            ((ex_e.dest == hz.id_rs) | (ex_e.dest == hz.id_rt));
    issue = hz.id_valid & ~hz.flush & ~stall;
  end

  // Selects for the ID instruction, used once it reaches EX.
  always_comb begin
    nxt_a = SEL_RF;
    nxt_b = SEL_RF;
    if (issue) begin
      nxt_a = pick(ex_e, mem_e, hz.id_rs);
      nxt_b = pick(ex_e, mem_e, hz.id_rt);
    end
  end

  // Scoreboard shift and registered selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_e  <= '0;
      mem_e <= '0;
      fwd_a <= SEL_RF;
      fwd_b <= SEL_RF;
    end else begin
      mem_e <= ex_e;
      if (issue)
        ex_e <= '{1'b1, hz.id_reg_write,
                  hz.id_mem_read, hz.id_dest};
      else
        ex_e <= '0;
      fwd_a <= nxt_a;
      fwd_b <= nxt_b;
    end
  end

  assign hz.stall = stall;
  assign hz.fwd_a = fwd_a;
  assign hz.fwd_b = fwd_b;

`ifdef FWD_WB_BYPASS_EN
  ent_t wb_e;

  // Oldest entry, about to write the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wb_e <= '0;
    else
      wb_e <= mem_e;
  end

  // ID read mux takes WB write data on a match.
  always_comb begin
    hz.id_bypass_a = hz.id_valid & live(wb_e) &
                     (wb_e.dest == hz.id_rs);
    hz.id_bypass_b = hz.id_valid & live(wb_e) &
                     (wb_e.dest == hz.id_rt);
  end
`else
  assign hz.id_bypass_a = 1'b0;
  assign hz.id_bypass_b = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: in-flight instruction model plus
// directed scenarios with literal expectations.
module tb_fwd_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fwd_hazard_ctrl_if #(.REG_AW(5), .SEL_W(2)) hz ();

  fwd_hazard_ctrl #(.REG_AW(5), .SEL_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    bit       v;
    bit       rw;
    bit       mr;
    bit [4:0] dest;
  } ins_t;

  // pipe[0] = in EX, pipe[1] = in MEM, pipe[2] = in WB
  ins_t     pipe [3];
  bit [1:0] m_fa;
  bit [1:0] m_fb;

  function automatic bit writes(input ins_t i);
    return i.v && i.rw && (i.dest != 5'd0);
  endfunction

  // Youngest producer still ahead of WB supplies the operand.
  function automatic bit [1:0] pick(input logic [4:0] src);
    bit [1:0] s;
    s = 2'b00;
    for (int age = 1; age >= 0; age--)
      if (writes(pipe[age]) && pipe[age].dest == src)
        s = (age == 0) ? 2'b10 : 2'b01;
    return s;
  endfunction

  function automatic bit m_stall();
    return hz.id_valid && !hz.flush && pipe[0].mr &&
           writes(pipe[0]) &&
           (pipe[0].dest == hz.id_rs ||
            pipe[0].dest == hz.id_rt);
  endfunction

  function automatic bit m_issue();
    return hz.id_valid && !hz.flush && !m_stall();
  endfunction

  function automatic bit m_byp(input logic [4:0] src);
`ifdef FWD_WB_BYPASS_EN
    return hz.id_valid && writes(pipe[2]) &&
           pipe[2].dest == src;
`else
    return (src == 5'd0) && 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
      m_fa    <= 2'b00;
      m_fb    <= 2'b00;
    end else begin
      m_fa    <= m_issue() ? pick(hz.id_rs) : 2'b00;
      m_fb    <= m_issue() ? pick(hz.id_rt) : 2'b00;
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      pipe[0] <= m_issue()
               ? ins_t'{1'b1, hz.id_reg_write,
                        hz.id_mem_read, hz.id_dest}
               : ins_t'(0);
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_stall", int'(hz.stall), int'(m_stall()));
    chk("m_fwd_a", int'(hz.fwd_a), int'(m_fa));
    chk("m_fwd_b", int'(hz.fwd_b), int'(m_fb));
    chk("m_byp_a", int'(hz.id_bypass_a),
        int'(m_byp(hz.id_rs)));
    chk("m_byp_b", int'(hz.id_bypass_b),
        int'(m_byp(hz.id_rt)));
  end

  task automatic drive(input bit v, input int rs, input int rt,
                       input int dest, input bit rw,
                       input bit mr, input bit fl);
    hz.id_valid     = v;
    hz.id_rs        = 5'(rs);
    hz.id_rt        = 5'(rt);
    hz.id_dest      = 5'(dest);
    hz.id_reg_write = rw;
    hz.id_mem_read  = mr;
    hz.flush        = fl;
  endtask

  task automatic step(input bit v, input int rs, input int rt,
                      input int dest, input bit rw,
                      input bit mr, input bit fl);
    @(posedge clk);
    #1;
    drive(v, rs, rt, dest, rw, mr, fl);
  endtask

  task automatic nop();
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_stall", int'(hz.stall), 0);
    chk("rst_fwd_a", int'(hz.fwd_a), 0);
    chk("rst_fwd_b", int'(hz.fwd_b), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // add $3 ; sub rs=3 rt=4
    step(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3, 4, 10, 1'b1, 1'b0, 1'b0);
    nop();
    @(negedge clk);
    chk("ex_fwd_a", int'(hz.fwd_a), 2);
    chk("ex_fwd_b", int'(hz.fwd_b), 0);
    idle(3);

    // add $3 ; nop ; or rs=4 rt=3
    step(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    nop();
    step(1'b1, 4, 3, 11, 1'b1, 1'b0, 1'b0);
    nop();
    @(negedge clk);
    chk("mem_fwd_a", int'(hz.fwd_a), 0);
    chk("mem_fwd_b", int'(hz.fwd_b), 1);
    idle(3);

    // lw $5 ; add rs=5 -> one stall then MEM forward
    step(1'b1, 1, 2, 5, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5, 6, 8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_stall1", int'(hz.stall), 1);
    step(1'b1, 5, 6, 8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_stall2", int'(hz.stall), 0);
    chk("lu_bubble", int'(hz.fwd_a), 0);
    nop();
    @(negedge clk);
    chk("lu_fwd_a", int'(hz.fwd_a), 1);
    idle(3);

    // $0 producers never forward nor stall
    step(1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 0, 0, 9, 1'b1, 1'b0, 1'b0);
    nop();
    @(negedge clk);
    chk("r0_fwd_a", int'(hz.fwd_a), 0);
    step(1'b1, 1, 2, 0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 0, 4, 9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("r0_lw_stall", int'(hz.stall), 0);
    idle(3);

    // two writers to $7: youngest wins, rs==rt
    step(1'b1, 1, 2, 7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1, 2, 7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7, 7, 12, 1'b1, 1'b0, 1'b0);
    nop();
    @(negedge clk);
    chk("young_fwd_a", int'(hz.fwd_a), 2);
    chk("young_fwd_b", int'(hz.fwd_b), 2);
    idle(3);

    // writer $7, two nops, rs=7 -> WB bypass only
    step(1'b1, 1, 2, 7, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 7, 4, 13, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
`ifdef FWD_WB_BYPASS_EN
    chk("wb_byp_a", int'(hz.id_bypass_a), 1);
`else
    chk("wb_byp_a", int'(hz.id_bypass_a), 0);
`endif
    chk("wb_byp_b", int'(hz.id_bypass_b), 0);
    idle(3);

    // flush wins over load-use stall
    step(1'b1, 1, 2, 9, 1'b1, 1'b1, 1'b0);
    step(1'b1, 9, 4, 14, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_stall", int'(hz.stall), 0);
    nop();
    @(negedge clk);
    chk("fl_fwd_a", int'(hz.fwd_a), 0);
    idle(3);

    // reset pulse mid-stream with live entries
    step(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3, 4, 2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 2, 6, 4, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", int'(hz.stall), 1);
    chk("pre_rst_fwd_a", int'(hz.fwd_a), 2);
    #1;
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("arst_stall", int'(hz.stall), 0);
    chk("arst_fwd_a", int'(hz.fwd_a), 0);
    chk("arst_fwd_b", int'(hz.fwd_b), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_a", int'(hz.fwd_a), 0);
      chk("post_rst_b", int'(hz.fwd_b), 0);
    end

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
